seq_detector_param: RTL and testbench

Parametrised serial bit-sequence detector. It is the next generation of the fixed-pattern 1101 Mealy/Moore detectors in MealyMoore_FSMs. Pattern, pattern length, overlap mode and Mealy/Moore output mode are run-time configurable. It also keeps a saturating match counter. It sits behind a serial bit source (one bit per qualified clock) and drives a single-cycle detect pulse to downstream logic.

---
 rtl/seq_detector_param.sv | 128 ++++++++++++
 tb/tb_seq_detector_param.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_param.sv
// seq_detector_param: run-time configurable serial bit-sequence detector.
//   Shifts in one bit per qualified clock and compares the newest pat_len bits
//   against a latched pattern. Overlapping or non-overlapping detection and
//   Mealy or Moore output timing are both selectable. A saturating counter
//   tracks detections.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   din_valid, din    qualified serial input bit
//   cfg_load          strobe that latches pattern/pat_len/overlap_en/moore_mode
//                     and clears history, fill and match_count
//   pattern, pat_len  target sequence (pattern[pat_len-1] arrives first) and its length
//   overlap_en        1 = a match suffix may start the next match
//   moore_mode        1 = registered detect pulse, 0 = combinational pulse
//   dout              detect pulse
//   match_count       saturating detection count
//   fill              bits accumulated toward the current candidate
module seq_detector_param #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din_valid,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic               overlap_en,
  input  logic               moore_mode,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   fill
);

  // One extra bit so fill+1 cannot wrap when LEN_W exactly fits MAX_LEN.
  localparam int unsigned FILL_W = LEN_W + 1;

  logic [MAX_LEN-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic               ovl_q,   ovl_d;
  logic               moore_q, moore_d;
  logic [MAX_LEN-1:0] hist_q,  hist_d;
  logic [LEN_W-1:0]   fill_q,  fill_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               dout_q,  dout_d;

  logic               adv_c;
  logic [MAX_LEN-1:0] next_hist_c;
  logic [MAX_LEN-1:0] mask_c;
  logic [FILL_W-1:0]  fill_inc_c;
  logic               hit_c;

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      moore_q <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      moore_q <= moore_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Match evaluation and next-state logic.
  always_comb begin
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    moore_d = moore_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    dout_d  = 1'b0;

    // A cfg_load cycle never consumes din.
    adv_c       = din_valid & ~cfg_load;
    next_hist_c = {hist_q[MAX_LEN-2:0], din};
    fill_inc_c  = FILL_W'(fill_q) + FILL_W'(1);

    // Only the low len_q history bits take part in the comparison.
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask_c[i] = (FILL_W'(i) < FILL_W'(len_q));
    end

    hit_c = adv_c && (len_q != '0) && (fill_inc_c >= FILL_W'(len_q)) &&
            (((next_hist_c ^ pat_q) & mask_c) == '0);

    if (cfg_load) begin
      pat_d   = pattern;
      len_d   = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
      ovl_d   = overlap_en;
      moore_d = moore_mode;
      hist_d  = '0;
      fill_d  = '0;
      cnt_d   = '0;
    end else if (din_valid) begin
      hist_d = next_hist_c;
      dout_d = hit_c;
      if (hit_c) begin
        // Overlap keeps the candidate full so the retained suffix can match again.
        fill_d = ovl_q ? len_q : '0;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        fill_d = (fill_inc_c > FILL_W'(len_q)) ? len_q : LEN_W'(fill_inc_c);
      end
    end
  end

  assign dout        = moore_q ? dout_q : hit_c;
  assign match_count = cnt_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios plus a
// randomized stream compared against a queue-based behavioural model.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               din_valid;
  logic               din;
  logic               cfg_load;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   pat_len;
  logic               overlap_en;
  logic               moore_mode;
  logic               dout;
  logic [CNT_W-1:0]   match_count;
  logic [LEN_W-1:0]   fill;

  int checks = 0;
  int errors = 0;

  // Behavioural model: every bit since configuration kept in a queue; a
  // candidate starts at m_start and a hit compares the newest len bits.
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  bit                 m_ovl;
  bit                 m_moore;
  bit                 m_bits[$];
  int                 m_start;
  int                 m_cnt;
  bit                 m_dq;

  // Values sampled mid-cycle by the last call to cycle().
  logic               obs_dout;
  logic [CNT_W-1:0]   obs_cnt;
  logic [LEN_W-1:0]   obs_fill;
  logic               exp_dout;
  logic [CNT_W-1:0]   exp_cnt;
  logic [LEN_W-1:0]   exp_fill;

  seq_detector_param #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din_valid  (din_valid),
    .din        (din),
    .cfg_load   (cfg_load),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .overlap_en (overlap_en),
    .moore_mode (moore_mode),
    .dout       (dout),
    .match_count(match_count),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  function automatic bit model_hit(bit d);
    int n;
    if (m_len == 0) return 1'b0;
    n = m_bits.size() + 1;
    if (n - m_start < m_len) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      bit b;
      b = (k == 0) ? d : m_bits[m_bits.size() - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic int model_fill();
    int f;
    f = m_bits.size() - m_start;
    return (f < m_len) ? f : m_len;
  endfunction

  task automatic model_reset();
    m_pat   = '0;
    m_len   = 0;
    m_ovl   = 1'b0;
    m_moore = 1'b0;
    m_bits.delete();
    m_start = 0;
    m_cnt   = 0;
    m_dq    = 1'b0;
  endtask

  // One clock: drive at posedge+1, sample at negedge, advance model after the edge.
  task automatic cycle(input bit v, input bit d, input bit cfg);
    bit h;
    din_valid = v;
    din       = d;
    cfg_load  = cfg;
    @(negedge clk);
    obs_dout = dout;
    obs_cnt  = match_count;
    obs_fill = fill;
    h        = (v && !cfg) ? model_hit(d) : 1'b0;
    exp_dout = m_moore ? m_dq : h;
    exp_cnt  = CNT_W'(m_cnt);
    exp_fill = LEN_W'(model_fill());
    @(posedge clk);
    #1;
    if (cfg) begin
      m_pat   = pattern;
      m_len   = (int'(pat_len) > int'(MAX_LEN)) ? int'(MAX_LEN) : int'(pat_len);
      m_ovl   = overlap_en;
      m_moore = moore_mode;
      m_bits.delete();
      m_start = 0;
      m_cnt   = 0;
    end else if (v) begin
      m_bits.push_back(d);
      if (h) begin
        if (m_cnt < CNT_MAX) m_cnt++;
        if (!m_ovl) m_start = m_bits.size();
      end
    end
    m_dq      = h;
    din_valid = 1'b0;
    cfg_load  = 1'b0;
  endtask

  task automatic load_cfg(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] l,
                          input bit ovl, input bit moore);
    pattern    = p;
    pat_len    = l;
    overlap_en = ovl;
    moore_mode = moore;
    cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    if (dout !== 1'b0) begin
      errors++; $display("FAIL reset_dout: got %0b expected 0", dout);
    end
    checks++;
    if (match_count !== '0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", match_count);
    end
    checks++;
    if (fill !== '0) begin
      errors++; $display("FAIL reset_fill: got %0d expected 0", fill);
    end
    checks++;
  endtask

  task automatic test_overlap_mealy();
    bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
    load_cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, s[i], 1'b0);
      if (obs_dout !== ((i == 3) || (i == 6))) begin
        errors++; $display("FAIL ovl_mealy_dout bit%0d: got %0b expected %0b", i + 1, obs_dout, (i == 3) || (i == 6));
      end
      checks++;
    end
    if (match_count !== CNT_W'(2)) begin
      errors++; $display("FAIL ovl_mealy_count: got %0d expected 2", match_count);
    end
    checks++;
  endtask

  task automatic test_nonoverlap();
    bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
    load_cfg(8'b0000_1101, 4'd4, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b1, s[i], 1'b0);
      if (obs_dout !== (i == 3)) begin
        errors++; $display("FAIL novl_dout bit%0d: got %0b expected %0b", i + 1, obs_dout, i == 3);
      end
      checks++;
    end
    if (match_count !== CNT_W'(1)) begin
      errors++; $display("FAIL novl_count: got %0d expected 1", match_count);
    end
    checks++;
    if (fill !== LEN_W'(3)) begin
      errors++; $display("FAIL novl_fill: got %0d expected 3", fill);
    end
    checks++;
  endtask

  task automatic test_moore();
    bit s[7] = '{1, 1, 0, 1, 1, 0, 1};
    load_cfg(8'b0000_1101, 4'd4, 1'b1, 1'b1);
    // Cycle i shows the registered result of bit i; cycle 7 is an idle cycle.
    for (int i = 0; i < 9; i++) begin
      if (i < 7) cycle(1'b1, s[i], 1'b0);
      else       cycle(1'b0, 1'b0, 1'b0);
      if (obs_dout !== ((i == 4) || (i == 7))) begin
        errors++; $display("FAIL moore_dout cycle%0d: got %0b expected %0b", i, obs_dout, (i == 4) || (i == 7));
      end
      checks++;
    end
    if (match_count !== CNT_W'(2)) begin
      errors++; $display("FAIL moore_count: got %0d expected 2", match_count);
    end
    checks++;
  endtask

  task automatic test_gaps_full();
    bit s[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    int vb;
    load_cfg(8'hA5, 4'd8, 1'b0, 1'b0);
    vb = 0;
    for (int i = 0; i < 11; i++) begin
      bit v;
      v = !(i >= 2 && i <= 4);
      if (v) begin
        cycle(1'b1, s[vb], 1'b0);
        vb++;
      end else begin
        cycle(1'b0, 1'b1, 1'b0);
      end
      if (obs_dout !== (v && vb == 8)) begin
        errors++; $display("FAIL gaps_dout cycle%0d: got %0b expected %0b", i, obs_dout, v && vb == 8);
      end
      checks++;
    end
    if (match_count !== CNT_W'(1)) begin
      errors++; $display("FAIL gaps_count: got %0d expected 1", match_count);
    end
    checks++;
    // cfg_load wins over a valid bit on the same cycle.
    cycle(1'b1, 1'b1, 1'b1);
    if (obs_dout !== 1'b0) begin
      errors++; $display("FAIL cfgload_dout: got %0b expected 0", obs_dout);
    end
    checks++;
    if (match_count !== '0 || fill !== '0) begin
      errors++; $display("FAIL cfgload_clear: got count %0d fill %0d expected 0 0", match_count, fill);
    end
    checks++;
  endtask

  task automatic test_saturation_clamp();
    bit s[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    load_cfg(8'h01, 4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (obs_dout !== 1'b1) begin
        errors++; $display("FAIL sat_dout bit%0d: got %0b expected 1", i + 1, obs_dout);
      end
      checks++;
      if (obs_cnt !== CNT_W'((i < CNT_MAX) ? i : CNT_MAX)) begin
        errors++; $display("FAIL sat_count bit%0d: got %0d expected %0d", i + 1, obs_cnt, (i < CNT_MAX) ? i : CNT_MAX);
      end
      checks++;
    end
    if (match_count !== CNT_W'(CNT_MAX)) begin
      errors++; $display("FAIL sat_final: got %0d expected %0d", match_count, CNT_MAX);
    end
    checks++;
    load_cfg(8'hA5, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, s[i], 1'b0);
      if (obs_dout !== (i == 7)) begin
        errors++; $display("FAIL clamp_dout bit%0d: got %0b expected %0b", i + 1, obs_dout, i == 7);
      end
      checks++;
      if (obs_fill !== LEN_W'(i)) begin
        errors++; $display("FAIL clamp_fill bit%0d: got %0d expected %0d", i + 1, obs_fill, i);
      end
      checks++;
    end
    if (match_count !== CNT_W'(1)) begin
      errors++; $display("FAIL clamp_count: got %0d expected 1", match_count);
    end
    checks++;
  endtask

  task automatic test_async_reset();
    bit s[7] = '{1, 1, 0, 1, 1, 1, 0};
    bit t[4] = '{1, 1, 0, 1};
    load_cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1, s[i], 1'b0);
    // A further 1 would complete 1101; reset between edges must win.
    din_valid = 1'b1;
    din       = 1'b1;
    reset     = 1'b0;
    #2;
    if (dout !== 1'b0) begin
      errors++; $display("FAIL areset_dout: got %0b expected 0", dout);
    end
    checks++;
    if (match_count !== '0) begin
      errors++; $display("FAIL areset_count: got %0d expected 0", match_count);
    end
    checks++;
    if (fill !== '0) begin
      errors++; $display("FAIL areset_fill: got %0d expected 0", fill);
    end
    checks++;
    @(negedge clk);
    reset     = 1'b1;
    din_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    load_cfg(8'b0000_1101, 4'd4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, t[i], 1'b0);
      if (obs_dout !== (i == 3)) begin
        errors++; $display("FAIL post_reset_dout bit%0d: got %0b expected %0b", i + 1, obs_dout, i == 3);
      end
      checks++;
    end
  endtask

  task automatic test_len0();
    for (int m = 0; m < 2; m++) begin
      load_cfg(8'h00, 4'd0, m[0], m[0]);
      for (int i = 0; i < 30; i++) begin
        cycle(1'b1, (m == 0) ? 1'b0 : 1'($urandom_range(0, 1)), 1'b0);
        if (obs_dout !== 1'b0 || obs_cnt !== '0) begin
          errors++; $display("FAIL len0 mode%0d cycle%0d: got dout %0b count %0d expected 0 0", m, i, obs_dout, obs_cnt);
        end
        checks++;
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 6; r++) begin
      load_cfg(MAX_LEN'($urandom), LEN_W'($urandom_range(1, 4)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
      for (int i = 0; i < 300; i++) begin
        // Config inputs change freely; only cfg_load may sample them.
        pattern    = MAX_LEN'($urandom);
        pat_len    = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 15))
                                                 : LEN_W'($urandom_range(1, 4));
        overlap_en = 1'($urandom_range(0, 1));
        moore_mode = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) == 0) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
        else cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'b0);
        if (obs_dout !== exp_dout) begin
          errors++; $display("FAIL rand_dout r%0d c%0d: got %0b expected %0b", r, i, obs_dout, exp_dout);
        end
        checks++;
        if (obs_cnt !== exp_cnt) begin
          errors++; $display("FAIL rand_count r%0d c%0d: got %0d expected %0d", r, i, obs_cnt, exp_cnt);
        end
        checks++;
        if (obs_fill !== exp_fill) begin
          errors++; $display("FAIL rand_fill r%0d c%0d: got %0d expected %0d", r, i, obs_fill, exp_fill);
        end
        checks++;
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    din_valid  = 1'b0;
    din        = 1'b0;
    cfg_load   = 1'b0;
    pattern    = '0;
    pat_len    = '0;
    overlap_en = 1'b0;
    moore_mode = 1'b0;
    model_reset();
    #3 reset = 1'b0;
    #4;
    test_reset();
    #5 reset = 1'b1;
    @(posedge clk);
    #1;
    test_overlap_mealy();
    test_nonoverlap();
    test_moore();
    test_gaps_full();
    test_saturation_clamp();
    test_async_reset();
    test_len0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
